// File: rtl/vga_sync_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_sync_gen
//  Purpose  : Parametrised VGA timing generator. Produces a pixel clock-enable
//             from the system clock, the horizontal/vertical sync levels,
//             the visible-region flag, composite sync and the pixel
//             coordinates. It also produces line/frame strobes and a frame
//             counter. Start and stop under 'enable' are frame-aligned.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk          in   system clock
//    Reset_n      in   asynchronous active-low reset
//    enable       in   request timing generation (stop waits for frame end)
//    pixel_ce     out  one-Clk pulse every CLK_DIV Clk cycles while active
//    hs / vs      out  sync levels, HS_POL / VS_POL while asserted
//    blank        out  1 only inside the visible region
//    sync         out  composite sync, active low
//    DrawX/DrawY  out  current horizontal / vertical counter
//    line_start   out  one-Clk pulse in the first cycle of DrawX=0
//    frame_start  out  one-Clk pulse in the first cycle of (0,0)
//    frame_count  out  completed frames, wraps modulo 2^FC_W
//    running      out  generator active (not idle)
// ============================================================================
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COORD_W  = 10,
  parameter int FC_W     = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               enable,
  output logic               pixel_ce,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic               sync,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               line_start,
  output logic               frame_start,
  output logic [FC_W-1:0]    frame_count,
  output logic               running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] X_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] Y_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [COORD_W-1:0]   x_q, x_d;
  logic [COORD_W-1:0]   y_q, y_d;
  logic [FC_W-1:0]      fc_q, fc_d;
  logic                 pce_q;
  logic                 hs_q, vs_q, blank_q, sync_q;
  logic                 ls_q, ls_d;
  logic                 fs_q, fs_d;
  logic                 run_q;

  logic                 x_last_w, y_last_w, frame_end_w;
  logic                 hs_act_w, vs_act_w;

  assign x_last_w    = (x_q == X_LAST);
  assign y_last_w    = (y_q == Y_LAST);
  // pce_q is only ever set outside IDLE, so it already implies an active state.
  assign frame_end_w = pce_q && x_last_w && y_last_w;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    x_d     = x_q;
    y_d     = y_q;
    fc_d    = fc_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;

    // Pixel divider and raster counters
    if (state_q == ST_IDLE) begin
      div_d = '0;
      x_d   = '0;
      y_d   = '0;
    end else begin
      div_d = pce_q ? '0 : div_q + 1'b1;
      if (pce_q) begin
        if (x_last_w) begin
          x_d  = '0;
          ls_d = 1'b1;
          if (y_last_w) begin
            y_d  = '0;
            fs_d = 1'b1;
            fc_d = fc_q + 1'b1;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
    end

    // Run control: stopping is only allowed on the last pixel of a frame,
    // so sync periods are never truncated however fast enable toggles.
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          ls_d    = 1'b1;
          fs_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (!enable) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (frame_end_w && !enable) begin
          // Counters wrap to (0,0) but no strobe is issued into IDLE.
          state_d = ST_IDLE;
          ls_d    = 1'b0;
          fs_d    = 1'b0;
        end else if (enable) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Decoded from the next coordinates so the registered levels always
    // describe the coordinates presented alongside them.
    hs_act_w = (x_d >= HS_FIRST) && (x_d <= HS_LAST);
    vs_act_w = (y_d >= VS_FIRST) && (y_d <= VS_LAST);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fc_q    <= '0;
      pce_q   <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      blank_q <= 1'b0;
      sync_q  <= 1'b1;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
      pce_q   <= (state_d != ST_IDLE) && (div_d == DIV_LAST);
      hs_q    <= hs_act_w ? HS_POL : ~HS_POL;
      vs_q    <= vs_act_w ? VS_POL : ~VS_POL;
      blank_q <= (state_d != ST_IDLE) && (x_d < X_VIS) && (y_d < Y_VIS);
      sync_q  <= ~(hs_act_w | vs_act_w);
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      run_q   <= (state_d != ST_IDLE);
    end
  end

  assign pixel_ce    = pce_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign sync        = sync_q;
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;
  assign running     = run_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_sync_gen
//  Purpose  : Self-checking bench for vga_sync_gen. Three instances (default
//             timing, a tiny 7x6 raster with a 2-bit frame counter, and a
//             15x9 raster with CLK_DIV=3 and inverted polarities) are checked
//             every cycle against an arithmetic raster model, plus a table of
//             hand-derived vectors and a few directed corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

  localparam int  P_HA  [3] = '{640, 4, 8};
  localparam int  P_HFP [3] = '{16, 1, 2};
  localparam int  P_HS  [3] = '{96, 1, 3};
  localparam int  P_HBP [3] = '{48, 1, 2};
  localparam int  P_VA  [3] = '{480, 3, 5};
  localparam int  P_VFP [3] = '{10, 1, 1};
  localparam int  P_VS  [3] = '{2, 1, 2};
  localparam int  P_VBP [3] = '{33, 1, 1};
  localparam int  P_D   [3] = '{2, 1, 3};
  localparam bit  P_HP  [3] = '{1'b0, 1'b1, 1'b0};
  localparam bit  P_VP  [3] = '{1'b0, 1'b0, 1'b1};
  localparam int  P_FCW [3] = '{16, 2, 16};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en    [3];
  logic        pce   [3];
  logic        hs    [3];
  logic        vs    [3];
  logic        blank [3];
  logic        sync  [3];
  logic        ls    [3];
  logic        fs    [3];
  logic        run   [3];
  logic [9:0]  dx    [3];
  logic [9:0]  dy    [3];
  logic [15:0] fc0, fc2;
  logic [1:0]  fc1;

  vga_sync_gen u0 (
    .Clk(clk), .Reset_n(rst_n), .enable(en[0]), .pixel_ce(pce[0]), .hs(hs[0]), .vs(vs[0]),
    .blank(blank[0]), .sync(sync[0]), .DrawX(dx[0]), .DrawY(dy[0]), .line_start(ls[0]),
    .frame_start(fs[0]), .frame_count(fc0), .running(run[0])
  );

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b0), .COORD_W(10), .FC_W(2)
  ) u1 (
    .Clk(clk), .Reset_n(rst_n), .enable(en[1]), .pixel_ce(pce[1]), .hs(hs[1]), .vs(vs[1]),
    .blank(blank[1]), .sync(sync[1]), .DrawX(dx[1]), .DrawY(dy[1]), .line_start(ls[1]),
    .frame_start(fs[1]), .frame_count(fc1), .running(run[1])
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(3), .HS_POL(1'b0), .VS_POL(1'b1), .COORD_W(10), .FC_W(16)
  ) u2 (
    .Clk(clk), .Reset_n(rst_n), .enable(en[2]), .pixel_ce(pce[2]), .hs(hs[2]), .vs(vs[2]),
    .blank(blank[2]), .sync(sync[2]), .DrawX(dx[2]), .DrawY(dy[2]), .line_start(ls[2]),
    .frame_start(fs[2]), .frame_count(fc2), .running(run[2])
  );

  // Reference model: clock cycles elapsed since the current frame began.
  int m_t   [3];
  int m_fr  [3];
  bit m_act [3];
  bit m_pen [3];

  int n_vec = 0;
  int n_bad = 0;

  typedef logic [43:0] obs_t;

  typedef struct packed {
    logic       en;
    logic [15:0] n;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
    logic [1:0] fc;
    logic       run;
  } vec_t;

  vec_t tbl [17];

  function automatic int h_tot(int i);
    return P_HA[i] + P_HFP[i] + P_HS[i] + P_HBP[i];
  endfunction

  function automatic int v_tot(int i);
    return P_VA[i] + P_VFP[i] + P_VS[i] + P_VBP[i];
  endfunction

  function automatic logic [15:0] fc_of(int i);
    case (i)
      0:       return fc0;
      1:       return {14'd0, fc1};
      default: return fc2;
    endcase
  endfunction

  function automatic obs_t actual(int i);
    return {pce[i], hs[i], vs[i], blank[i], sync[i], dx[i], dy[i], ls[i], fs[i], fc_of(i), run[i]};
  endfunction

  function automatic obs_t expected(int i);
    int   p, x, y, ph, hs0, vs0;
    logic hsa, vsa, pce_e, bl_e, ls_e, fs_e, hs_e, vs_e;
    logic [15:0] fce;
    fce = 16'(m_fr[i]);
    if (!m_act[i])
      return {1'b0, ~P_HP[i], ~P_VP[i], 1'b0, 1'b1, 10'd0, 10'd0, 2'b00, fce, 1'b0};
    ph    = m_t[i] % P_D[i];
    p     = m_t[i] / P_D[i];
    x     = p % h_tot(i);
    y     = p / h_tot(i);
    hs0   = P_HA[i] + P_HFP[i];
    vs0   = P_VA[i] + P_VFP[i];
    hsa   = (x >= hs0) && (x < hs0 + P_HS[i]);
    vsa   = (y >= vs0) && (y < vs0 + P_VS[i]);
    hs_e  = hsa ? P_HP[i] : ~P_HP[i];
    vs_e  = vsa ? P_VP[i] : ~P_VP[i];
    pce_e = (ph == P_D[i] - 1);
    bl_e  = (x < P_HA[i]) && (y < P_VA[i]);
    ls_e  = (ph == 0) && (x == 0);
    fs_e  = ls_e && (y == 0);
    return {pce_e, hs_e, vs_e, bl_e, ~(hsa | vsa), 10'(x), 10'(y), ls_e, fs_e, fce, 1'b1};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0;
      m_t[i]   = 0;
      m_fr[i]  = 0;
      m_pen[i] = 1'b0;
    end
  endtask

  // A frame ends in idle only if enable was low at both of its last two edges.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b0;
        m_t[i]   = 0;
        m_fr[i]  = 0;
        m_pen[i] = 1'b0;
      end else if (!m_act[i]) begin
        if (en[i]) begin
          m_act[i] = 1'b1;
          m_t[i]   = 0;
        end
        m_pen[i] = en[i];
      end else begin
        if (m_t[i] == P_D[i] * h_tot(i) * v_tot(i) - 1) begin
          m_fr[i] = (m_fr[i] + 1) % (1 << P_FCW[i]);
          m_t[i]  = 0;
          if (!en[i] && !m_pen[i]) m_act[i] = 1'b0;
        end else begin
          m_t[i] = m_t[i] + 1;
        end
        m_pen[i] = en[i];
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (actual(i) !== expected(i)) begin
        n_bad++;
        $display("FAIL model u%0d t=%0d: got %h, want %h", i, m_t[i], actual(i), expected(i));
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_en(input int i);
    if ($urandom_range(0, 47) == 0) en[i] = ~en[i];
  endtask

  initial begin
    //           en    n      x      y      hs    vs    blank fs    fc    run
    tbl[0]  = '{1'b0, 16'd3,  10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 16'd1,  10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[2]  = '{1'b1, 16'd5,  10'd5, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[3]  = '{1'b1, 16'd36, 10'd6, 10'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[4]  = '{1'b1, 16'd1,  10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[5]  = '{1'b1, 16'd28, 10'd0, 10'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
    tbl[6]  = '{1'b1, 16'd56, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1};
    tbl[7]  = '{1'b1, 16'd42, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[8]  = '{1'b0, 16'd10, 10'd3, 10'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[9]  = '{1'b0, 16'd31, 10'd6, 10'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[10] = '{1'b0, 16'd1,  10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[11] = '{1'b0, 16'd5,  10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[12] = '{1'b1, 16'd1,  10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[13] = '{1'b1, 16'd10, 10'd3, 10'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1};
    tbl[14] = '{1'b0, 16'd5,  10'd1, 10'd2, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1};
    tbl[15] = '{1'b1, 16'd27, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1};
    tbl[16] = '{1'b0, 16'd42, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) en[i] = 1'b0;
    model_reset();
    @(negedge clk);
    repeat (3) step();
    chk("rst_u2_hs", 32'(hs[2]), 32'd1);
    chk("rst_u2_vs", 32'(vs[2]), 32'd0);
    chk("rst_u1_hs", 32'(hs[1]), 32'd0);
    chk("rst_u0_sync", 32'(sync[0]), 32'd1);
    rst_n = 1'b1;

    // Table-driven sequence on the 7x6 instance
    for (int e = 0; e < 17; e++) begin
      en[1] = tbl[e].en;
      for (int k = 0; k < int'(tbl[e].n); k++) begin
        rand_en(2);
        step();
      end
      chk($sformatf("tbl[%0d]", e),
          32'({dx[1], dy[1], hs[1], vs[1], blank[1], fs[1], fc1, run[1]}),
          32'({tbl[e].x, tbl[e].y, tbl[e].hs, tbl[e].vs, tbl[e].blank, tbl[e].fs, tbl[e].fc, tbl[e].run}));
    end

    // Default 640x480 timing: line-level landmarks counted from entry
    en[0] = 1'b1;
    for (int k = 1; k <= 1700; k++) begin
      rand_en(1);
      rand_en(2);
      step();
      case (k - 1)
        0:    begin chk("def_fs0", 32'(fs[0]), 32'd1); chk("def_ls0", 32'(ls[0]), 32'd1); end
        1279: chk("def_blank_x639", 32'(blank[0]), 32'd1);
        1280: chk("def_blank_x640", 32'(blank[0]), 32'd0);
        1311: chk("def_hs_x655", 32'(hs[0]), 32'd1);
        1312: begin chk("def_hs_x656", 32'(hs[0]), 32'd0); chk("def_pce_even", 32'(pce[0]), 32'd0); end
        1313: chk("def_pce_odd", 32'(pce[0]), 32'd1);
        1503: chk("def_hs_x751", 32'(hs[0]), 32'd0);
        1504: chk("def_hs_x752", 32'(hs[0]), 32'd1);
        1600: begin chk("def_line1_y", 32'(dy[0]), 32'd1); chk("def_line1_ls", 32'(ls[0]), 32'd1); end
        default: ;
      endcase
    end

    // Asynchronous reset at DrawX=300 of the default instance
    begin
      bit found;
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
        if (m_act[0] && m_t[0] % 2 == 0 && (m_t[0] / 2) % 800 == 300) found = 1'b1;
        else step();
      end
      chk("find_x300", 32'(found), 32'd1);
      chk("pre_rst_x", 32'(dx[0]), 32'd300);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_x", 32'(dx[0]), 32'd0);
      chk("arst_y", 32'(dy[0]), 32'd0);
      chk("arst_fc0", 32'(fc0), 32'd0);
      chk("arst_fc1", 32'(fc1), 32'd0);
      chk("arst_hs", 32'(hs[0]), 32'd1);
      chk("arst_vs", 32'(vs[0]), 32'd1);
      chk("arst_blank", 32'(blank[0]), 32'd0);
      chk("arst_run", 32'(run[0]), 32'd0);
      model_reset();
      @(negedge clk);
      step();
      rst_n = 1'b1;
    end

    // Randomized enable traffic on all instances
    for (int k = 0; k < 15000; k++) begin
      for (int i = 0; i < 3; i++) rand_en(i);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
